// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the multi-channel button/switch debouncer.
//   - rep_state_t : per-button auto-repeat FSM state
//   - cnt_width() : bits needed for a counter that must hold 0..max_val
//   - max2()      : larger of two integers, used to size shared counters
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-flop synchroniser, tick-based stability counter,
//   debounced level and an IDLE/DELAY/REPEAT auto-repeat FSM.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   tick          debounce sample strobe from the shared tick generator
//   btn_raw       raw button pin, active-high, asynchronous
//   repeat_en     auto-repeat enable for this channel, synchronous
//   level         debounced button state
//   press         one-cycle pulse on accepted press or auto-repeat
//   release_pulse one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int STAB_W = cnt_width(STABLE_TICKS);
  localparam int REP_W  = cnt_width(max2(REPEAT_DELAY, REPEAT_RATE));

  // Counters compare against max-1 so the pulse lands on the same edge on
  // which the increment would have reached the limit.
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_TICKS - 1);
  localparam logic [REP_W-1:0]  DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]  RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic              sync1, sync2;
  logic [STAB_W-1:0] stab_cnt;
  logic [REP_W-1:0]  rep_cnt;
  rep_state_t        state;
  logic              accept, rise, fall;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept = 1'b0;
    rise   = 1'b0;
    fall   = 1'b0;
    if (tick && (sync2 != level) && (stab_cnt == STAB_LAST)) begin
      accept = 1'b1;
      rise   = ~level;
      fall   = level;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // this block samples the pre-edge values, independent of statement order.
  // The synchroniser flops are reset too: after reset the zero state is then
  // debounced toward the pins like any other change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      stab_cnt      <= '0;
      level         <= 1'b0;
      state         <= IDLE;
      rep_cnt       <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;

      if (tick) begin
        if (sync2 == level) begin
          stab_cnt <= '0;
        end else if (accept) begin
          stab_cnt <= '0;
          level    <= ~level;
        end else begin
          stab_cnt <= stab_cnt + STAB_W'(1);
        end
      end

      press         <= 1'b0;
      release_pulse <= 1'b0;

      // A falling level overrides anything the FSM would do this cycle,
      // which keeps press and release mutually exclusive.
      if (fall) begin
        state         <= IDLE;
        rep_cnt       <= '0;
        release_pulse <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state   <= DELAY;
              rep_cnt <= '0;
              press   <= 1'b1;
            end
          end
          DELAY: begin
            if (!repeat_en) begin
              rep_cnt <= '0;
            end else if (tick) begin
              if (rep_cnt == DELAY_LAST) begin
                press   <= 1'b1;
                state   <= REPEAT;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
              end
            end
          end
          REPEAT: begin
            if (!repeat_en) begin
              state   <= DELAY;
              rep_cnt <= '0;
            end else if (tick) begin
              if (rep_cnt == RATE_LAST) begin
                press   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + REP_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            rep_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer_n.sv
// -----------------------------------------------------------------------------
// button_debouncer_n
//   Multi-channel push-button debouncer with per-channel auto-repeat, plus a
//   debounced switch bank. Sits between board pins and drawing/colour control.
//
// Ports
//   clk           system clock (only clock)
//   rst_n         asynchronous active-low reset
//   btn_raw       raw button pins, active-high, asynchronous
//   sw_raw        raw switch pins, asynchronous
//   repeat_en     per-channel auto-repeat enable, synchronous
//   level         debounced button states
//   press         one-cycle pulses: accepted press or auto-repeat
//   release_pulse one-cycle pulses on accepted release
//   sw_out        debounced switch value
//   sw_changed    one-cycle pulse when sw_out updates
// -----------------------------------------------------------------------------
module button_debouncer_n
  import debounce_pkg::*;
#(
  parameter int NUM_BTN      = 2,
  parameter int SW_WIDTH     = 8,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic [NUM_BTN-1:0]  repeat_en,
  output logic [NUM_BTN-1:0]  level,
  output logic [NUM_BTN-1:0]  press,
  output logic [NUM_BTN-1:0]  release_pulse,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                sw_changed
);

  localparam int SW_CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [SW_CNT_W-1:0] SW_LAST = SW_CNT_W'(STABLE_TICKS - 1);

  logic tick;

  // ---------------------------------------------------------------------------
  // Shared sample tick: high in the cycle the divider sits at TICK_DIV-1.
  // ---------------------------------------------------------------------------
  if (TICK_DIV == 1) begin : g_tick_every
    assign tick = 1'b1;
  end else begin : g_tick_div
    localparam int TW = cnt_width(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end

    assign tick = (tick_cnt == TICK_LAST);
  end

  // ---------------------------------------------------------------------------
  // Button channels
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (tick),
      .btn_raw       (btn_raw[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Switch bank, debounced as one vector. A sample only counts toward a change
  // if it matches the previous tick's sample, so a short excursion through an
  // intermediate value restarts the count instead of being loaded.
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_sync1, sw_sync2, sw_prev;
  logic [SW_CNT_W-1:0] sw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync1   <= '0;
      sw_sync2   <= '0;
      sw_prev    <= '0;
      sw_cnt     <= '0;
      sw_out     <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_sync1   <= sw_raw;
      sw_sync2   <= sw_sync1;
      sw_changed <= 1'b0;
      if (tick) begin
        sw_prev <= sw_sync2;
        if ((sw_sync2 != sw_out) && (sw_sync2 == sw_prev)) begin
          if (sw_cnt == SW_LAST) begin
            sw_out     <= sw_sync2;
            sw_changed <= 1'b1;
            sw_cnt     <= '0;
          end else begin
            sw_cnt <= sw_cnt + SW_CNT_W'(1);
          end
        end else begin
          sw_cnt <= '0;
        end
      end
    end
  end

endmodule
